// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master: it issues word-aligned fetch requests and
// receives at most one response per accepted request.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage. Keeps at most one imem request in flight, parks a
// response in a one-entry skid buffer when ID is stalled, and discards the
// in-flight response after a redirect by means of a kill flag.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  if_stage_if.master  imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request pending or about to be issued
    WAIT  = 2'd1,  // one request outstanding
    HOLD  = 2'd2   // response parked in the skid buffer
  } state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_ALN = {RESET_PC[31:2], 2'b00};

  state_e      state_q,      state_d;
  logic [31:0] fetch_pc_q,   fetch_pc_d;
  logic [31:0] req_pc_q,     req_pc_d;
  logic        kill_q,       kill_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_valid_q,   if_valid_d;
  logic [31:0] if_pc_q,      if_pc_d;
  logic [31:0] if_instr_q,   if_instr_d;
  logic        req_valid_q,  req_valid_d;

  logic        req_fire;
  logic        req_stuck;
  logic [31:0] redirect_pc_aln;

  assign req_fire        = req_valid_q && imem.imem_req_ready;
  // A presented request that has not been accepted must stay up unchanged.
  assign req_stuck       = req_valid_q && !imem.imem_req_ready && !redirect;
  assign redirect_pc_aln = redirect_pc & 32'hFFFF_FFFC;

  // Next-state logic for the fetch FSM, skid buffer and ID-facing outputs.
  always_comb begin
    // NOTE: every variable gets its hold value first so that no path through
    // the branches below leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;

    // ID takes the displayed instruction; it disappears unless replaced below.
    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

    if (redirect) begin
      // Redirect outranks stall and any response; skid contents are dropped
      // simply by leaving HOLD.
      fetch_pc_d = redirect_pc_aln;
      if_valid_d = 1'b0;
      unique case (state_q)
        FETCH: begin
          if (req_fire) begin
            state_d = WAIT;
            kill_d  = 1'b1;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            state_d = FETCH;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        HOLD: begin
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (req_fire) begin
            state_d    = WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = FETCH;
            end else if (!if_valid_q || !stall) begin
              if_valid_d = 1'b1;
              if_pc_d    = req_pc_q;
              if_instr_d = imem.imem_rsp_data;
              state_d    = FETCH;
            end else begin
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem.imem_rsp_data;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_instr_d = skid_instr_q;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end

    // Request is registered: raised for the next cycle when the FSM will be in
    // FETCH and ID is not sitting stalled on a live instruction.
    req_valid_d = (state_d == FETCH) && (req_stuck || !(if_valid_d && stall));
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC_ALN;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      // NOTE: the skid registers are reset too; they are a single entry, so
      // this is cheap and keeps them free of X after reset.
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      req_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // the values computed in the same cycle.
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      req_valid_q  <= req_valid_d;
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_req_addr  = fetch_pc_q;
  assign if_valid            = if_valid_q;
  assign if_pc               = if_pc_q;
  assign if_instr            = if_instr_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a one-cycle-latency memory model returns
// addr ^ 32'h00A0_0013, and every instruction ID sees is popped from a queue
// of expected PCs filled when the scenario is set up.
module tb_if_stage;

  localparam logic [31:0] K = 32'h00A0_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  if_stage_if imem ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .imem        (imem),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop   = 0;
  int          cyc     = 0;
  logic [31:0] sb[$];
  int          pop_cyc[$];

  bit          mem_en;
  logic [31:0] blk_addr;
  int          blk_cnt;
  bit          blk_on;
  logic        hs;
  logic [31:0] hs_addr;
  logic        prev_valid;
  logic        prev_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: memory handshake at negedge, response and monitor after posedge.
  task automatic step();
    logic [31:0] exp_pc;
    @(negedge clk);
    if (blk_cnt > 0 && (blk_on || (imem.imem_req_valid && imem.imem_req_addr == blk_addr))) begin
      if (blk_on) begin
        check("blk_addr_held", imem.imem_req_addr, blk_addr);
        check("blk_valid_held", {31'b0, imem.imem_req_valid}, 32'd1);
        check("blk_no_ifvalid", {31'b0, if_valid}, 32'd0);
      end
      blk_on = 1'b1;
      imem.imem_req_ready = 1'b0;
      blk_cnt--;
      if (blk_cnt == 0) blk_on = 1'b0;
    end else begin
      imem.imem_req_ready = mem_en;
    end
    #1;
    hs         = imem.imem_req_valid && imem.imem_req_ready;
    hs_addr    = imem.imem_req_addr;
    prev_valid = if_valid;
    prev_stall = stall;
    @(posedge clk);
    #1;
    cyc++;
    imem.imem_rsp_valid = hs;
    imem.imem_rsp_data  = hs_addr ^ K;
    if (rst_n && if_valid && !(prev_valid && prev_stall)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_instr", if_pc, 32'hFFFF_FFFF ^ if_pc);
      end else begin
        exp_pc = sb.pop_front();
        check("if_pc", if_pc, exp_pc);
        check("if_instr", if_instr, exp_pc ^ K);
        n_pop++;
        pop_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (n_pop < n && k < budget) begin
      step();
      k++;
    end
    check("wait_pops", n_pop, n);
  endtask

  initial begin
    rst_n               = 1'b0;
    stall               = 1'b0;
    redirect            = 1'b0;
    redirect_pc         = '0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    mem_en              = 1'b1;
    blk_addr            = '0;
    blk_cnt             = 0;
    blk_on              = 1'b0;
    prev_valid          = 1'b0;
    prev_stall          = 1'b0;

    // Reset state.
    repeat (3) step();
    check("rst_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'h0000_0013);

    // Expected display stream: 0x10 and 0x104 are killed by redirects.
    sb.push_back(32'h0000_0000);
    sb.push_back(32'h0000_0004);
    sb.push_back(32'h0000_0008);
    sb.push_back(32'h0000_000C);
    sb.push_back(32'h0000_0100);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);

    // Memory refuses the request at 0x8 for three cycles.
    blk_addr = 32'h0000_0008;
    blk_cnt  = 3;

    // Release: request rises one cycle later, at RESET_PC.
    rst_n = 1'b1;
    #1;
    check("rel_req_low", {31'b0, imem.imem_req_valid}, 32'd0);
    step();
    check("first_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    check("first_req_addr", imem.imem_req_addr, 32'd0);

    // Zero-wait stream: one instruction every two cycles.
    wait_pops(2, 20);
    if (pop_cyc.size() >= 2) check("pulse_gap", pop_cyc[1] - pop_cyc[0], 32'd2);

    // 0x8 comes through after the blocked cycles.
    wait_pops(3, 20);

    // Stall while 0x8 is displayed: 0xC response parks in the skid buffer.
    stall = 1'b1;
    step();
    step();
    check("hold_pc", if_pc, 32'h0000_0008);
    check("hold_valid", {31'b0, if_valid}, 32'd1);
    check("hold_no_req", {31'b0, imem.imem_req_valid}, 32'd0);
    step();
    check("hold_pc2", if_pc, 32'h0000_0008);
    check("hold_no_req2", {31'b0, imem.imem_req_valid}, 32'd0);
    stall = 1'b0;
    step();
    check("unstall_pc", if_pc, 32'h0000_000C);
    check("unstall_valid", {31'b0, if_valid}, 32'd1);

    // Redirect to 0x103 coincident with the 0x10 handshake.
    check("pre_redir_addr", imem.imem_req_addr, 32'h0000_0010);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check("kill_no_req", {31'b0, imem.imem_req_valid}, 32'd0);
    check("redir_addr", imem.imem_req_addr, 32'h0000_0100);
    step();
    check("kill_dropped", {31'b0, if_valid}, 32'd0);
    check("kill_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    check("kill_req_addr", imem.imem_req_addr, 32'h0000_0100);
    wait_pops(5, 20);

    // Redirect with stall, coincident with the 0x104 response; wrap at the top.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    stall       = 1'b1;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    check("wrap_addr", imem.imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    check("redir_rsp_dropped", {31'b0, if_valid}, 32'd0);
    wait_pops(7, 20);
    mem_en = 1'b0;

    // Reset during WAIT, stale response in the first cycle after release.
    mem_en = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, imem.imem_req_valid}, 32'd0);
    check("mid_rst_ifvalid", {31'b0, if_valid}, 32'd0);
    step();
    step();
    sb.push_back(32'h0000_0000);
    rst_n               = 1'b1;
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'hDEAD_BEEF;
    check("rel2_req_low", {31'b0, imem.imem_req_valid}, 32'd0);
    step();
    check("stale_ignored", {31'b0, if_valid}, 32'd0);
    check("rel2_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    check("rel2_req_addr", imem.imem_req_addr, 32'd0);
    wait_pops(8, 20);
    mem_en = 1'b0;
    repeat (4) step();
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
